// File: rtl/cla_operand_sequencer.sv
// cla_operand_sequencer: feeds a W-bit CLA adder and chains two passes for 2W-bit add/subtract
module cla_operand_sequencer #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] in_a,
  input  logic [2*W-1:0] in_b,
  input  logic           in_cin,
  input  logic           in_sub,
  input  logic           in_wide,
  output logic [W-1:0]   add_a,
  output logic [W-1:0]   add_b,
  output logic           add_cin,
  input  logic [W:0]     add_sum,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_sum,
  output logic           out_cout,
  output logic           out_ovf
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
  state_t state, state_n;
  logic [2*W-1:0] a_r, b_r;
  logic [W-1:0] res_lo;
  logic c_r, wide_r, carry_r;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = in_valid ? LOW : IDLE;
      LOW: state_n = wide_r ? HIGH : DONE;
      HIGH: state_n = DONE;
      DONE: state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
    in_ready = state == IDLE;
    out_valid = state == DONE;
    add_a = state == LOW ? a_r[W-1:0] : state == HIGH ? a_r[2*W-1:W] : '0;
    add_b = state == LOW ? b_r[W-1:0] : state == HIGH ? b_r[2*W-1:W] : '0;
    add_cin = state == LOW ? c_r : state == HIGH ? carry_r : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_r <= '0;
      b_r <= '0;
      c_r <= 1'b0;
      wide_r <= 1'b0;
      res_lo <= '0;
      carry_r <= 1'b0;
      out_sum <= '0;
      out_cout <= 1'b0;
      out_ovf <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid) begin
        a_r <= in_a;
        b_r <= in_sub ? ~in_b : in_b;
        c_r <= in_sub | in_cin;
        wide_r <= in_wide;
      end
      if (state == LOW) begin
        res_lo <= add_sum[W-1:0];
        carry_r <= add_sum[W];
        if (!wide_r) begin
          out_sum <= {{W{1'b0}}, add_sum[W-1:0]};
          out_cout <= add_sum[W];
          out_ovf <= (a_r[W-1] == b_r[W-1]) && (add_sum[W-1] != a_r[W-1]);
        end
      end
      if (state == HIGH) begin
        out_sum <= {add_sum[W-1:0], res_lo};
        out_cout <= add_sum[W];
        out_ovf <= (a_r[2*W-1] == b_r[2*W-1]) && (add_sum[W-1] != a_r[2*W-1]);
      end
    end
  end
endmodule

// File: tb/tb_cla_operand_sequencer.sv
// tb_cla_operand_sequencer: directed checks of the sequencer against a behavioural adder
module tb_cla_operand_sequencer;
  localparam int W = 32;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, in_cin = 1'b0, in_sub = 1'b0, in_wide = 1'b0;
  logic [2*W-1:0] in_a = '0, in_b = '0, out_sum;
  logic [W-1:0] add_a, add_b;
  logic add_cin, out_valid, out_ready = 1'b0, out_cout, out_ovf;
  logic [W:0] add_sum;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  assign add_sum = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
  cla_operand_sequencer #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub), .in_wide(in_wide),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic start(input logic [63:0] a, input logic [63:0] b, input logic cin,
                       input logic sub, input logic wide);
    for (int n = 0; n < 20 && !in_ready; n++) step();
    chk("ready_before_req", in_ready, 1'b1);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_wide = wide; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic sub, input logic wide, input logic hcin,
                        input logic [63:0] esum, input logic ecout, input logic eovf);
    start(a, b, cin, sub, wide);
    chk({tag, "_busy"}, in_ready, 1'b0);
    if (wide) begin
      chk({tag, "_valid_early"}, out_valid, 1'b0);
      step();
      chk({tag, "_high_cin"}, add_cin, hcin);
      chk({tag, "_valid_early2"}, out_valid, 1'b0);
    end
    step();
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_sum"}, out_sum, esum);
    chk({tag, "_cout"}, out_cout, ecout);
    chk({tag, "_ovf"}, out_ovf, eovf);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, out_valid, 1'b0);
    chk({tag, "_ready_back"}, in_ready, 1'b1);
  endtask
  initial begin
    repeat (2) step();
    rst = 1'b0;
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_sum", out_sum, 64'h0);
    chk("rst_cout", out_cout, 1'b0);
    chk("rst_ovf", out_ovf, 1'b0);
    chk("rst_add_a", add_a, 64'h0);
    run_op("w_add_wrap", 64'hDEADBEEF_FFFFFFFF, 64'h1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    run_op("w_add_cin", 64'h1, 64'h2, 1'b1, 1'b0, 1'b0, 1'b0, 64'h4, 1'b0, 1'b0);
    run_op("w_sub_cin_ign", 64'd10, 64'd3, 1'b1, 1'b1, 1'b0, 1'b0, 64'd7, 1'b1, 1'b0);
    run_op("d_add_chain", 64'h00000000_FFFFFFFF, 64'h1, 1'b0, 1'b0, 1'b1, 1'b1,
           64'h00000001_00000000, 1'b0, 1'b0);
    run_op("d_sub_borrow", 64'd5, 64'd7, 1'b0, 1'b1, 1'b1, 1'b0, 64'hFFFFFFFF_FFFFFFFE, 1'b0, 1'b0);
    run_op("d_sub_pos", 64'd7, 64'd5, 1'b0, 1'b1, 1'b1, 1'b1, 64'd2, 1'b1, 1'b0);
    run_op("w_ovf_pos", 64'h7FFFFFFF, 64'h1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h80000000, 1'b0, 1'b1);
    run_op("w_ovf_neg", 64'h80000000, 64'h80000000, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
    run_op("d_ovf_pos", 64'h7FFFFFFF_FFFFFFFF, 64'h1, 1'b0, 1'b0, 1'b1, 1'b1,
           64'h80000000_00000000, 1'b0, 1'b1);
    // back-pressure: result must hold and a stray request must not be latched
    start(64'd3, 64'd4, 1'b0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      in_valid = (i == 1); in_a = 64'd100; in_b = 64'd100;
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_sum", out_sum, 64'd7);
      chk("bp_ready", in_ready, 1'b0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_ready_after", in_ready, 1'b1);
    chk("bp_valid_after", out_valid, 1'b0);
    run_op("bp_next", 64'h10, 64'h20, 1'b0, 1'b0, 1'b0, 1'b0, 64'h30, 1'b0, 1'b0);
    // reset while in HIGH abandons the request
    start(64'h12345678_9ABCDEF0, 64'h1, 1'b0, 1'b0, 1'b1);
    step();
    chk("rst_mid_in_high_cin", add_cin, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_ready", in_ready, 1'b1);
    chk("rst_mid_valid", out_valid, 1'b0);
    chk("rst_mid_sum", out_sum, 64'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_mid_no_emit", out_valid, 1'b0);
    end
    out_ready = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
